merge_sequencer: RTL and testbench

MERGE_SEQUENCER -- requirements
Module: merge_sequencer

---
 rtl/merge_sequencer.sv | 122 ++++++++++++
 tb/tb_merge_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/merge_sequencer.sv
// Sequences merge16 batches into an in-order first-word-fall-through result FIFO; MERGE_SEQ_DROP_EMPTY_EN skips empty batches.
// Latency: accept to out_valid is MRG_LATENCY+1 cycles. Backpressure: in_ready reserves a FIFO slot per batch; unaccepted batches are dropped and counted.
module merge_sequencer #(
  parameter int MXADRBITS   = 11,
  parameter int MXCNTBITS   = 3,
  parameter int MRG_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clock4x,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_vpfs,
  output logic [15:0]            mrg_vpfs,
  input  logic [8*MXADRBITS-1:0] mrg_adr,
  input  logic [8*MXCNTBITS-1:0] mrg_cnt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*MXADRBITS-1:0] out_adr,
  output logic [8*MXCNTBITS-1:0] out_cnt,
  output logic [3:0]             out_ncl,
  output logic                   out_trunc,
  output logic [15:0]            drop_cnt,
  output logic                   busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [MRG_LATENCY-1:0] tag_vld_q;
  logic [4:0]             tag_pc_q [MRG_LATENCY];
  logic [CW-1:0]          fifo_count_q, fifo_count_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;

  logic [8*MXADRBITS-1:0] mem_adr_q   [FIFO_DEPTH];
  logic [8*MXCNTBITS-1:0] mem_cnt_q   [FIFO_DEPTH];
  logic [3:0]             mem_ncl_q   [FIFO_DEPTH];
  logic                   mem_trunc_q [FIFO_DEPTH];

  logic       accept, drop, push, pop, tag_exit;
  logic [4:0] exit_pc;
  logic [3:0] exit_ncl;
  logic [CW:0] occupancy;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  // Every accepted batch holds a slot from accept until pop, so the FIFO can never overflow.
  assign occupancy = {1'b0, fifo_count_q} + {1'b0, inflight_q};
  assign in_ready  = occupancy < (CW+1)'(FIFO_DEPTH);
  assign accept    = in_valid & in_ready & ~reset;
  assign drop      = in_valid & ~in_ready & ~reset;
  assign mrg_vpfs  = accept ? in_vpfs : 16'h0000;

  assign tag_exit = tag_vld_q[MRG_LATENCY-1];
  assign exit_pc  = tag_pc_q[MRG_LATENCY-1];
  assign exit_ncl = (exit_pc > 5'd8) ? 4'd8 : exit_pc[3:0];
`ifdef MERGE_SEQ_DROP_EMPTY_EN
  assign push = tag_exit & (exit_pc != 5'd0);
`else
  assign push = tag_exit;
`endif
  assign out_valid = fifo_count_q != '0;
  assign pop       = out_valid & out_ready;

  always_comb begin
    fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
    inflight_d   = inflight_q + CW'(accept) - CW'(tag_exit);
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    drop_cnt_d   = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clock4x) begin
    if (reset) begin
      fifo_count_q <= '0;
      inflight_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      drop_cnt_q   <= '0;
      tag_vld_q    <= '0;
      for (int i = 0; i < MRG_LATENCY; i++) tag_pc_q[i] <= '0;
    end else begin
      fifo_count_q <= fifo_count_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_cnt_q   <= drop_cnt_d;
      tag_vld_q[0] <= accept;
      tag_pc_q[0]  <= popcnt16(in_vpfs);
      for (int i = 1; i < MRG_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_pc_q[i]  <= tag_pc_q[i-1];
      end
    end
  end

  // Storage is not reset; the output mux hides stale contents whenever the FIFO is empty.
  always_ff @(posedge clock4x) begin
    if (push) begin
      mem_adr_q[wr_ptr_q]   <= mrg_adr;
      mem_cnt_q[wr_ptr_q]   <= mrg_cnt;
      mem_ncl_q[wr_ptr_q]   <= exit_ncl;
      mem_trunc_q[wr_ptr_q] <= exit_pc > 5'd8;
    end
  end

  assign out_adr   = out_valid ? mem_adr_q[rd_ptr_q]   : '1;
  assign out_cnt   = out_valid ? mem_cnt_q[rd_ptr_q]   : '1;
  assign out_ncl   = out_valid ? mem_ncl_q[rd_ptr_q]   : 4'd0;
  assign out_trunc = out_valid ? mem_trunc_q[rd_ptr_q] : 1'b0;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = (fifo_count_q != '0) || (inflight_q != '0);

endmodule

// File: tb/tb_merge_sequencer.sv
// Randomized scoreboard bench for merge_sequencer with a delay-line merge16 stand-in.
module tb_merge_sequencer;
  localparam int L     = 1;
  localparam int DEPTH = 4;
  localparam int AB    = 11;
  localparam int CB    = 3;
`ifdef MERGE_SEQ_DROP_EMPTY_EN
  localparam bit DROPE = 1'b1;
`else
  localparam bit DROPE = 1'b0;
`endif

  logic              clock4x = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_vpfs = 16'h0;
  logic [15:0]       mrg_vpfs;
  logic [8*AB-1:0]   mrg_adr;
  logic [8*CB-1:0]   mrg_cnt;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [8*AB-1:0]   out_adr;
  logic [8*CB-1:0]   out_cnt;
  logic [3:0]        out_ncl;
  logic              out_trunc;
  logic [15:0]       drop_cnt;
  logic              busy;

  merge_sequencer #(.MXADRBITS(AB), .MXCNTBITS(CB), .MRG_LATENCY(L), .FIFO_DEPTH(DEPTH)) dut (
    .clock4x(clock4x), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_vpfs(in_vpfs), .mrg_vpfs(mrg_vpfs), .mrg_adr(mrg_adr), .mrg_cnt(mrg_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_adr(out_adr), .out_cnt(out_cnt),
    .out_ncl(out_ncl), .out_trunc(out_trunc), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clock4x = ~clock4x;

  typedef struct {
    logic [8*AB-1:0] adr;
    logic [8*CB-1:0] cnt;
    logic [3:0]      ncl;
    logic            trunc;
    int              rdy;
    bit              drop;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          in_rst = 1'b1;
  logic [15:0] exp_drop = 16'h0;

  // merge16 stand-in: whatever the batch's candidate data is, it appears MRG_LATENCY cycles later.
  logic [8*AB-1:0] cand_adr = '1;
  logic [8*CB-1:0] cand_cnt = '0;
  logic [8*AB-1:0] madr [L];
  logic [8*CB-1:0] mcnt [L];
  always @(posedge clock4x) begin
    madr[0] <= (mrg_vpfs != 16'h0) ? cand_adr : '1;
    mcnt[0] <= (mrg_vpfs != 16'h0) ? cand_cnt : '0;
    for (int i = 1; i < L; i++) begin
      madr[i] <= madr[i-1];
      mcnt[i] <= mcnt[i-1];
    end
  end
  assign mrg_adr = madr[L-1];
  assign mrg_cnt = mcnt[L-1];

  always @(posedge clock4x) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Empty batches in drop mode reserve a slot only until they leave the merge pipeline.
  task automatic purge();
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].drop && sbq[i].rdy <= cyc) sbq.delete(i);
  endtask

  function automatic logic [8*AB-1:0] rnd_adr();
    logic [8*AB-1:0] a;
    for (int s = 0; s < 8; s++) a[s*AB +: AB] = AB'($urandom_range(0, (1 << AB) - 1));
    return a;
  endfunction

  function automatic logic [8*CB-1:0] rnd_cnt();
    logic [8*CB-1:0] c;
    for (int s = 0; s < 8; s++) c[s*CB +: CB] = CB'($urandom_range(0, (1 << CB) - 1));
    return c;
  endfunction

  task automatic step(input bit v, input logic [15:0] vp, input bit ordy,
                      input logic [8*AB-1:0] adr, input logic [8*CB-1:0] cnt);
    bit   exp_ready;
    bit   acc;
    int   pc;
    exp_t e;
    @(posedge clock4x);
    #1;
    purge();
    exp_ready = sbq.size() < DEPTH;
    acc = v && exp_ready;
    in_valid = v; in_vpfs = vp; out_ready = ordy; cand_adr = adr; cand_cnt = cnt;
    #1;
    chk("in_ready", 128'(in_ready), 128'(exp_ready));
    chk("drop_cnt", 128'(drop_cnt), 128'(exp_drop));
    chk("busy", 128'(busy), 128'(sbq.size() != 0));
    chk("mrg_vpfs", 128'(mrg_vpfs), 128'(acc ? vp : 16'h0));
    if (acc) begin
      pc = $countones(vp);
      e.adr   = (vp == 16'h0) ? '1 : adr;
      e.cnt   = (vp == 16'h0) ? '0 : cnt;
      e.ncl   = 4'((pc > 8) ? 8 : pc);
      e.trunc = pc > 8;
      e.rdy   = cyc + L + 1;
      e.drop  = DROPE && (vp == 16'h0);
      sbq.push_back(e);
    end else if (v && exp_drop != 16'hFFFF) begin
      exp_drop = exp_drop + 16'd1;
    end
  endtask

  task automatic rstep(input bit v, input logic [15:0] vp, input bit ordy);
    step(v, vp, ordy, rnd_adr(), rnd_cnt());
  endtask

  task automatic do_reset(input int n);
    @(posedge clock4x);
    #1;
    in_rst = 1'b1; reset = 1'b1; in_valid = 1'b1; in_vpfs = 16'hFFFF; out_ready = 1'b0;
    repeat (n) @(posedge clock4x);
    #1;
    reset = 1'b0; in_valid = 1'b0; in_vpfs = 16'h0;
    sbq.delete();
    exp_drop = 16'h0;
    in_rst = 1'b0;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_drop_cnt", 128'(drop_cnt), 128'(16'h0));
    chk("rst_out_ncl", 128'(out_ncl), 128'(4'h0));
    chk("rst_out_trunc", 128'(out_trunc), 128'(1'b0));
    chk("rst_out_adr", 128'(out_adr), 128'({8*AB{1'b1}}));
    chk("rst_out_cnt", 128'(out_cnt), 128'({8*CB{1'b1}}));
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 40) begin
      rstep(1'b0, 16'h0, 1'b1);
      k++;
    end
    chk("drain_done", 128'(sbq.size()), 128'(0));
  endtask

  // Monitor: checks the head of the FIFO against the scoreboard every cycle, pops on handshake.
  always @(negedge clock4x) begin
    bit ev;
    if (!in_rst) begin
      purge();
      ev = (sbq.size() != 0) && (sbq[0].rdy <= cyc);
      chk("out_valid", 128'(out_valid), 128'(ev));
      if (ev) begin
        chk("out_adr", 128'(out_adr), 128'(sbq[0].adr));
        chk("out_cnt", 128'(out_cnt), 128'(sbq[0].cnt));
        chk("out_ncl", 128'(out_ncl), 128'(sbq[0].ncl));
        chk("out_trunc", 128'(out_trunc), 128'(sbq[0].trunc));
        if (out_ready) void'(sbq.pop_front());
      end else begin
        chk("idle_out_adr", 128'(out_adr), 128'({8*AB{1'b1}}));
        chk("idle_out_ncl", 128'(out_ncl), 128'(4'h0));
      end
    end
  end

  initial begin
    logic [8*AB-1:0] a27;
    a27 = '1;
    a27[AB-1:0]    = AB'(7);
    a27[2*AB-1:AB] = AB'(12);

    do_reset(3);

    step(1'b1, 16'h0005, 1'b1, a27, rnd_cnt());
    repeat (3) rstep(1'b0, 16'h0, 1'b1);
    rstep(1'b1, 16'hFFFF, 1'b1);
    rstep(1'b1, 16'h01FF, 1'b1);
    rstep(1'b1, 16'h00FF, 1'b1);
    drain();

    repeat (8) rstep(1'b1, 16'($urandom), 1'b0);
    drain();

    for (int i = 0; i < 20; i++) rstep(1'b1, 16'($urandom), 1'b1);
    drain();

    rstep(1'b1, 16'h0000, 1'b1);
    drain();

    repeat (4) rstep(1'b1, 16'($urandom), 1'b0);
    do_reset(1);
    repeat (10) rstep(1'b0, 16'h0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [15:0] vp;
      r = $urandom_range(0, 9);
      vp = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
      rstep($urandom_range(0, 3) != 0, vp, $urandom_range(0, 3) != 0);
      if (i == 200) do_reset(2);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
